// File: rtl/aq_axis_sync_fifo.sv
// Single-clock first-word-fall-through AXI4-Stream FIFO holding {TLAST, TDATA}.
// Status flags come from a registered occupancy count; thresholds are live inputs.
module aq_axis_sync_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  RST,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic                  S_AXIS_TLAST,
  input  logic [FIFO_WIDTH-1:0] S_AXIS_TDATA,
  output logic                  FIFO_WR_FULL,
  output logic                  FIFO_WR_ALM_FULL,
  input  logic [FIFO_DEPTH:0]   FIFO_WR_ALM_COUNT,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [FIFO_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic                  FIFO_RD_EMPTY,
  output logic                  FIFO_RD_ALM_EMPTY,
  input  logic [FIFO_DEPTH:0]   FIFO_RD_ALM_COUNT
);

  localparam int                    ENTRIES  = 1 << FIFO_DEPTH;
  localparam logic [FIFO_DEPTH:0]   CNT_FULL = (FIFO_DEPTH+1)'(ENTRIES);
  localparam logic [FIFO_DEPTH:0]   CNT_ONE  = (FIFO_DEPTH+1)'(1);
  localparam logic [FIFO_DEPTH-1:0] PTR_ONE  = FIFO_DEPTH'(1);
  localparam logic [FIFO_DEPTH+1:0] CAP_WIDE = (FIFO_DEPTH+2)'(ENTRIES);

  logic [FIFO_WIDTH:0]   mem_q [ENTRIES];
  logic [FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH:0]   count_q, count_d;
  logic                  full, empty, wr_en, rd_en;
  logic [FIFO_DEPTH+1:0] alm_full_sum;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign wr_en = S_AXIS_TVALID && !full;
  assign rd_en = M_AXIS_TREADY && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ACLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_en) mem_q[wr_ptr_q] <= {S_AXIS_TLAST, S_AXIS_TDATA};
    end
  end

  // Widened sum so a margin at or above capacity keeps almost-full asserted.
  assign alm_full_sum = {1'b0, count_q} + {1'b0, FIFO_WR_ALM_COUNT};

  assign {M_AXIS_TLAST, M_AXIS_TDATA} = mem_q[rd_ptr_q];
  assign M_AXIS_TVALID     = !empty;
  assign S_AXIS_TREADY     = !full && !RST;
  assign FIFO_WR_FULL      = full;
  assign FIFO_RD_EMPTY     = empty;
  assign FIFO_WR_ALM_FULL  = !RST && (alm_full_sum >= CAP_WIDE);
  assign FIFO_RD_ALM_EMPTY = (count_q <= FIFO_RD_ALM_COUNT);

endmodule

// File: tb/tb_aq_axis_sync_fifo.sv
// Bench for aq_axis_sync_fifo: directed scenarios plus random traffic checked
// against a queue-based model of the FIFO contents.
module tb_aq_axis_sync_fifo;
  localparam int D = 4;
  localparam int W = 32;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_tvalid, s_tready, s_tlast;
  logic [W-1:0] s_tdata;
  logic         full, alm_full, m_tvalid, m_tready, m_tlast, empty, alm_empty;
  logic [W-1:0] m_tdata;
  logic [D:0]   wr_alm, rd_alm;

  int total  = 0;
  int passed = 0;

  logic [W:0] q[$];
  logic [W:0] last_pop;
  bit         popped;

  always #5 clk = ~clk;

  aq_axis_sync_fifo #(.FIFO_DEPTH(D), .FIFO_WIDTH(W)) dut (
    .ACLK(clk), .RST(rst),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TDATA(s_tdata),
    .FIFO_WR_FULL(full), .FIFO_WR_ALM_FULL(alm_full), .FIFO_WR_ALM_COUNT(wr_alm),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TLAST(m_tlast),
    .FIFO_RD_EMPTY(empty), .FIFO_RD_ALM_EMPTY(alm_empty), .FIFO_RD_ALM_COUNT(rd_alm)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_flags();
    int sz;
    sz = q.size();
    chk("full",      full,      sz == N);
    chk("alm_full",  alm_full,  !rst && (sz >= N - int'(wr_alm)));
    chk("empty",     empty,     sz == 0);
    chk("alm_empty", alm_empty, sz <= int'(rd_alm));
    chk("m_tvalid",  m_tvalid,  sz != 0);
    chk("s_tready",  s_tready,  !rst && (sz != N));
    if (sz != 0) chk("head", {m_tlast, m_tdata}, q[0]);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    bit wr, rd;
    wr = s_tvalid && (q.size() < N);
    rd = m_tready && (q.size() > 0);
    popped = 1'b0;
    if (rd) begin
      chk("pop_data", {m_tlast, m_tdata}, q[0]);
      last_pop = q[0];
      popped   = 1'b1;
    end
    @(posedge clk);
    if (rd) void'(q.pop_front());
    if (wr) q.push_back({s_tlast, s_tdata});
    #1;
    check_flags();
    @(negedge clk);
  endtask

  initial begin
    int exp_v, wrote;
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0;
    wr_alm = 5'd4; rd_alm = 5'd2;
    q.delete();
    repeat (2) @(negedge clk);

    // Reset state, then ready rises as soon as reset drops
    check_flags();
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tlast", m_tlast, 0);
    rst = 1'b0;
    #1;
    check_flags();
    chk("post_rst_tready", s_tready, 1);
    @(negedge clk);

    // Fill with 0..19, no reads
    s_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_tdata = W'(i);
      cycle();
      if (i == 10) chk("alm_full_after_11", alm_full, 0);
      if (i == 11) chk("alm_full_after_12", alm_full, 1);
      if (i == 14) chk("full_after_15", full, 0);
      if (i == 15) chk("full_after_16", full, 1);
    end
    chk("fill_tready", s_tready, 0);

    // Drain for 20 cycles
    s_tvalid = 1'b0; m_tready = 1'b1; exp_v = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (popped) begin
        chk("drain_order", last_pop[W-1:0], W'(exp_v));
        exp_v++;
      end
    end
    chk("drain_count", exp_v, 16);
    chk("drain_empty", empty, 1);

    // Streaming: writes 0..19, reader joins at cycle 9
    exp_v = 0; wrote = 0;
    for (int c = 0; c < 40; c++) begin
      s_tvalid = (wrote < 20);
      s_tdata  = W'(wrote);
      m_tready = (c >= 9);
      cycle();
      if (s_tvalid) wrote++;
      if (popped) begin
        chk("stream_order", last_pop[W-1:0], W'(exp_v));
        exp_v++;
      end
      if (c >= 9 && c < 19) chk("stream_empty", empty, 0);
    end
    chk("stream_count", exp_v, 20);

    // Corner: write+read on a full FIFO
    s_tvalid = 1'b1; m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_tdata = $urandom;
      s_tlast = 1'($urandom);
      cycle();
    end
    m_tready = 1'b1; s_tdata = 32'hDEAD_BEEF;
    chk("full_rw_tready", s_tready, 0);
    cycle();
    chk("full_rw_full", full, 0);
    chk("full_rw_almfull", alm_full, 1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (20) cycle();

    // Corner: write+read on an empty FIFO
    s_tvalid = 1'b1; m_tready = 1'b1; s_tdata = 32'h1234;
    chk("empty_rw_tvalid_pre", m_tvalid, 0);
    cycle();
    chk("empty_rw_tvalid", m_tvalid, 1);
    chk("empty_rw_head", m_tdata, 32'h1234);
    s_tvalid = 1'b0;
    cycle();

    // TLAST tracks word 7 only
    m_tready = 1'b0; s_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_tdata = W'(i);
      s_tlast = (i == 7);
      cycle();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (m_tvalid) chk("tlast_head", m_tlast, m_tdata == 32'd7);
      cycle();
    end

    // Reset with 10 words stored
    m_tready = 1'b0; s_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_tdata = W'(100 + i);
      cycle();
    end
    s_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    q.delete();
    chk("mid_rst_empty", empty, 1);
    check_flags();
    @(negedge clk);
    rst = 1'b0;
    s_tvalid = 1'b1; s_tdata = 32'hA5;
    cycle();
    s_tvalid = 1'b0;
    chk("mid_rst_first", m_tdata, 32'hA5);
    m_tready = 1'b1;
    cycle();

    // Random traffic with thresholds changing at run time
    for (int c = 0; c < 600; c++) begin
      if (c % 25 == 0) begin
        wr_alm = 5'($urandom_range(0, 20));
        rd_alm = 5'($urandom_range(0, 17));
      end
      s_tvalid = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 70 : 35));
      m_tready = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 35 : 70));
      s_tdata  = $urandom;
      s_tlast  = 1'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
